pipelined_shifter: RTL and testbench

//   Parametrised, pipelined barrel shifter/rotator for the NPC datapath. Performs
//   SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand in log2(WIDTH) shift levels,

---
 rtl/pipelined_shifter_if.sv | 27 ++
 rtl/pipelined_shifter.sv | 107 ++++++++++
 tb/tb_pipelined_shifter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for the pipelined shifter: operand/op/tag in, result/tag out,
// each direction with its own valid/ready pair.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [$clog2(WIDTH)-1:0] in_shamt;
    logic [2:0]               in_op;
    logic [TAG_W-1:0]         in_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [TAG_W-1:0]         out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator (SLL/SRL/SRA/ROL/ROR) with valid/ready flow
// control; log2(WIDTH) shift levels spread over STAGES register stages.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_shifter_if.slave bus
);
    localparam int L = $clog2(WIDTH);

    // Lowest shift level handled by stage s (level k lives in stage floor(k*STAGES/L)).
    function automatic int first_level(input int s);
        return (s * L + STAGES - 1) / STAGES;
    endfunction

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] v,
                                                     input logic [2:0]       op,
                                                     input int               n);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        case (op)
            3'b000:  return v << n;
            3'b001:  return v >> n;
            3'b010:  return sv >>> n;
            3'b100:  return (v << n) | (v >> (WIDTH - n));
            3'b101:  return (v >> n) | (v << (WIDTH - n));
            default: return v;
        endcase
    endfunction

    // The whole pipe moves in lockstep; bubbles are held, not collapsed.
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = first_level(s);
        localparam int HI = first_level(s + 1);

        logic                 src_vld;
        logic [WIDTH-1:0]     src_data;
        logic [TAG_W-1:0]     src_tag;
        logic [2:0]           src_op;
        logic [L-LO-1:0]      src_shamt;
        logic [WIDTH-1:0]     res;
        logic                 vld_p;
        logic [WIDTH-1:0]     data_p;
        logic [TAG_W-1:0]     tag_p;

        if (s == 0) begin : g_src
            assign src_vld   = bus.in_valid;
            assign src_data  = bus.in_data;
            assign src_tag   = bus.in_tag;
            assign src_op    = bus.in_op;
            assign src_shamt = bus.in_shamt;
        end else begin : g_src
            assign src_vld   = g_stage[s-1].vld_p;
            assign src_data  = g_stage[s-1].data_p;
            assign src_tag   = g_stage[s-1].tag_p;
            assign src_op    = g_stage[s-1].g_ctl.op_p;
            assign src_shamt = g_stage[s-1].g_ctl.shamt_p;
        end

        always_comb begin
            res = src_data;
            for (int k = LO; k < HI; k++) begin
                if (src_shamt[k-LO]) res = shift_level(res, src_op, 1 << k);
            end
        end

        // --- stage s register boundary ---
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p  <= 1'b0;
                data_p <= '0;
                tag_p  <= '0;
            end else if (adv) begin
                vld_p  <= src_vld;
                data_p <= res;
                tag_p  <= src_tag;
            end
        end

        // Only the shamt bits of levels still ahead are carried forward.
        if (s < STAGES - 1) begin : g_ctl
            logic [2:0]      op_p;
            logic [L-HI-1:0] shamt_p;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_p    <= '0;
                    shamt_p <= '0;
                end else if (adv) begin
                    op_p    <= src_op;
                    shamt_p <= src_shamt[L-LO-1:HI-LO];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].vld_p;
    assign bus.out_data  = g_stage[STAGES-1].data_p;
    assign bus.out_tag   = g_stage[STAGES-1].tag_p;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed cases on an 8-bit/3-stage instance and
// randomized traffic on 8-bit/1-stage and 32-bit/5-stage instances vs. a reference model.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        d_valid, d_ready;
    logic [31:0] d_data, d_exp;
    logic [4:0]  d_shamt;
    logic [2:0]  d_op;
    logic [3:0]  d_tag;
    int          sel;

    pipelined_shifter_if #(.WIDTH(8),  .TAG_W(4)) if_a ();
    pipelined_shifter_if #(.WIDTH(8),  .TAG_W(4)) if_b ();
    pipelined_shifter_if #(.WIDTH(32), .TAG_W(4)) if_c ();

    pipelined_shifter #(.WIDTH(8),  .STAGES(3), .TAG_W(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    pipelined_shifter #(.WIDTH(8),  .STAGES(1), .TAG_W(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(4)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.in_valid  = d_valid && (sel == 0);
    assign if_a.in_data   = d_data[7:0];
    assign if_a.in_shamt  = d_shamt[2:0];
    assign if_a.in_op     = d_op;
    assign if_a.in_tag    = d_tag;
    assign if_a.out_ready = d_ready;
    assign if_b.in_valid  = d_valid && (sel == 1);
    assign if_b.in_data   = d_data[7:0];
    assign if_b.in_shamt  = d_shamt[2:0];
    assign if_b.in_op     = d_op;
    assign if_b.in_tag    = d_tag;
    assign if_b.out_ready = d_ready;
    assign if_c.in_valid  = d_valid && (sel == 2);
    assign if_c.in_data   = d_data;
    assign if_c.in_shamt  = d_shamt;
    assign if_c.in_op     = d_op;
    assign if_c.in_tag    = d_tag;
    assign if_c.out_ready = d_ready;

    logic        cur_in_ready, cur_out_valid;
    logic [31:0] cur_out_data;
    logic [3:0]  cur_out_tag;

    always_comb begin
        cur_in_ready  = if_c.in_ready;
        cur_out_valid = if_c.out_valid;
        cur_out_data  = if_c.out_data;
        cur_out_tag   = if_c.out_tag;
        if (sel == 0) begin
            cur_in_ready  = if_a.in_ready;
            cur_out_valid = if_a.out_valid;
            cur_out_data  = {24'h0, if_a.out_data};
            cur_out_tag   = if_a.out_tag;
        end else if (sel == 1) begin
            cur_in_ready  = if_b.in_ready;
            cur_out_valid = if_b.out_valid;
            cur_out_data  = {24'h0, if_b.out_data};
            cur_out_tag   = if_b.out_tag;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          acc;
    } beat_t;

    beat_t q[$];
    int    n_vec   = 0;
    int    n_fail  = 0;
    int    adv_cnt = 0;

    function automatic int cur_stages();
        return (sel == 0) ? 3 : (sel == 1) ? 1 : 5;
    endfunction

    function automatic int cur_w();
        return (sel == 2) ? 32 : 8;
    endfunction

    // Shift/rotate of the low w bits of d, straight from the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                              input logic [2:0] op, input int w);
        logic [31:0] m, x, r;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = d & m;
        case (op)
            3'd0: r = (x << sh) & m;
            3'd1: r = x >> sh;
            3'd2: begin
                r = x >> sh;
                if (x[w-1]) r = r | (m & ~(m >> sh));
            end
            3'd4: r = ((x << sh) | (x >> (w - sh))) & m;
            3'd5: r = ((x >> sh) | (x << (w - sh))) & m;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] data, input int sh, input logic [2:0] op,
                         input logic [3:0] tag, input logic [31:0] exp);
        d_valid = 1'b1;
        d_data  = data;
        d_shamt = 5'(sh);
        d_op    = op;
        d_tag   = tag;
        d_exp   = exp;
    endtask

    task automatic rand_beat();
        logic [31:0] data;
        logic [2:0]  op;
        int          sh;
        data = $urandom;
        op   = 3'($urandom_range(0, 7));
        sh   = int'($urandom_range(0, cur_w() - 1));
        drive(data, sh, op, 4'($urandom), ref_shift(data, sh, op, cur_w()));
    endtask

    // One clock: check any beat leaving, then record any beat entering.
    // The pipe only moves on edges where it advances, so a beat shows up on
    // the output after STAGES-1 further advancing edges.
    task automatic cycle();
        bit    acc, pop, advance;
        beat_t e;
        #1;
        acc     = d_valid && cur_in_ready;
        pop     = cur_out_valid && d_ready;
        advance = cur_in_ready;
        if (cur_out_valid && q.size() == 0) begin
            chk("spurious_out_valid", 32'(cur_out_valid), 32'd0);
        end else if (pop) begin
            e = q.pop_front();
            chk("out_data", cur_out_data, e.data);
            chk("out_tag", 32'(cur_out_tag), 32'(e.tag));
            chk("latency", 32'(adv_cnt), 32'(e.acc + cur_stages() - 1));
        end
        @(posedge clk);
        if (advance) adv_cnt++;
        if (acc) q.push_back('{d_exp, d_tag, adv_cnt});
        #1;
    endtask

    task automatic drain(input string name);
        d_valid = 1'b0;
        d_ready = 1'b1;
        repeat (cur_stages() + 3) cycle();
        chk(name, 32'(q.size()), 32'd0);
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            d_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) rand_beat();
            else d_valid = 1'b0;
            cycle();
        end
        drain("rand_drained");
        d_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_beat();
            cycle();
        end
        drain("burst_drained");
    endtask

    initial begin
        logic [2:0] ops [5];
        logic [7:0] exps[5];
        ops  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        exps = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};

        rst = 1'b1; d_valid = 1'b0; d_ready = 1'b0;
        d_data = '0; d_exp = '0; d_shamt = '0; d_op = '0; d_tag = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
        chk("rst_out_data", 32'(if_a.out_data), 32'd0);
        chk("rst_out_tag", 32'(if_a.out_tag), 32'd0);
        chk("rst_in_ready", 32'(if_a.in_ready), 32'd1);
        chk("rst_c_out_valid", 32'(if_c.out_valid), 32'd0);
        rst = 1'b0;

        // Fixed operand through every op.
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h96, 3, ops[i], 4'(i + 1), 32'(exps[i]));
            cycle();
        end
        drain("t1_drained");

        // Back-to-back rotate-right sweep.
        for (int i = 0; i < 8; i++) begin
            drive(32'h81, i, 3'd5, 4'(i),
                  (i == 0) ? 32'h81 : (i == 1) ? 32'hC0 : ref_shift(32'h81, i, 3'd5, 8));
            cycle();
        end
        drain("t2_drained");

        // Backpressure: pipe fills to capacity and holds.
        d_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_beat();
            d_tag = 4'(i);
            d_exp = ref_shift(d_data, int'(d_shamt), d_op, 8);
            cycle();
            if (i >= 3) chk("stall_hold_data", cur_out_data, q[0].data);
        end
        chk("stall_accepted", 32'(q.size()), 32'd3);
        chk("stall_in_ready", 32'(cur_in_ready), 32'd0);
        chk("stall_out_valid", 32'(cur_out_valid), 32'd1);
        chk("stall_hold_tag", 32'(cur_out_tag), 32'd0);
        drain("t3_drained");

        // Reserved ops, SRA extremes, zero shift.
        drive(32'h5A, 5, 3'b110, 4'hA, 32'h5A); cycle();
        drive(32'h7F, 7, 3'b010, 4'hB, 32'h00); cycle();
        drive(32'h80, 7, 3'b010, 4'hC, 32'hFF); cycle();
        drive(32'hA5, 4, 3'b011, 4'hD, 32'hA5); cycle();
        drive(32'h3C, 2, 3'b111, 4'hE, 32'h3C); cycle();
        drive(32'hE7, 0, 3'b000, 4'hF, 32'hE7); cycle();
        drain("t4_drained");

        // Reset with beats in flight, in_valid held high during reset.
        drive(32'h11, 1, 3'd0, 4'h1, 32'h22); cycle();
        drive(32'h33, 1, 3'd0, 4'h2, 32'h66); cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        d_valid = 1'b0;
        q.delete();
        chk("t5_out_valid", 32'(cur_out_valid), 32'd0);
        chk("t5_out_data", cur_out_data, 32'd0);
        chk("t5_out_tag", 32'(cur_out_tag), 32'd0);
        chk("t5_in_ready", 32'(cur_in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_no_ghost", 32'(cur_out_valid), 32'd0);
        end

        sel = 1;
        random_phase(300);
        sel = 2;
        random_phase(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
